// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches take every slot they request, CPU accesses fill the rest.
// Define VRAM_ARB_WBUF_EN to add a one-entry posted write buffer on the CPU path.
module vram_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {TagNone, TagDisp, TagCpuRd, TagCpuWr} tag_e;
  typedef enum logic [1:0] {StIdle, StBusy, StWait} state_e;

  state_e            state_q, state_d;
  tag_e              tag1_q, tag1_d, tag2_q, tag2_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_new;

  // A request still high alongside its own ack is the tail of the old one.
  assign cpu_new = cpu_req & ~cpu_ack_q;

`ifdef VRAM_ARB_WBUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
`endif

  always_comb begin
    state_d      = state_q;
    tag1_d       = TagNone;
    tag2_d       = tag1_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ack_d    = 1'b0;
`ifdef VRAM_ARB_WBUF_EN
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
`endif

    // Stage 2: ram_rdata belongs to the access tagged here.
    case (tag2_q)
      TagDisp: begin
        disp_data_d  = ram_rdata;
        disp_valid_d = 1'b1;
      end
      TagCpuRd: begin
        cpu_rdata_d = ram_rdata;
        cpu_ack_d   = 1'b1;
      end
      TagCpuWr: cpu_ack_d = 1'b1;
      default: ;
    endcase

    if (disp_req) begin
      ram_addr_d = disp_addr;
      tag1_d     = TagDisp;
    end

`ifdef VRAM_ARB_WBUF_EN
    if (!disp_req && buf_valid_q) begin
      ram_addr_d  = buf_addr_q;
      ram_we_d    = 1'b1;
      ram_wdata_d = buf_wdata_q;
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_new) begin
          if (cpu_we && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = cpu_addr;
            buf_wdata_d = cpu_wdata;
            cpu_ack_d   = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        // Reads wait for the buffer to drain so they observe the posted write.
        if (!buf_valid_q) begin
          if (cpu_we) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = cpu_addr;
            buf_wdata_d = cpu_wdata;
            cpu_ack_d   = 1'b1;
            state_d     = StIdle;
          end else if (!disp_req) begin
            ram_addr_d = cpu_addr;
            tag1_d     = TagCpuRd;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (tag2_q == TagCpuRd) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`else
    unique case (state_q)
      StIdle: begin
        if (cpu_new) state_d = StBusy;
      end
      StBusy: begin
        if (!disp_req) begin
          ram_addr_d  = cpu_addr;
          ram_we_d    = cpu_we;
          ram_wdata_d = cpu_wdata;
          tag1_d      = cpu_we ? TagCpuWr : TagCpuRd;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (tag2_q == TagCpuRd || tag2_q == TagCpuWr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`endif
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tag1_q       <= TagNone;
      tag2_q       <= TagNone;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
    end
  end

`ifdef VRAM_ARB_WBUF_EN
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
    end
  end
`endif

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = cpu_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: display-only scan, randomized CPU/display traffic against a slot-level
// reference model, then a reset in the middle of a CPU read and a display fetch.
module tb_vram_arbiter;
  localparam int NCYC       = 1800;
  localparam int NDISP_ONLY = 256;
  localparam int TAIL       = 40;
  localparam int ALEN       = NCYC + 64;

  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b0;
  logic        disp_req  = 1'b0;
  logic [12:0] disp_addr = '0;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        cpu_req   = 1'b0;
  logic        cpu_we    = 1'b0;
  logic [12:0] cpu_addr  = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  vram_arbiter dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Synchronous-read RAM; never-written bytes read as addr[7:0]^0x5A (the preload pattern).
  bit [7:0] ram_mem [8192];
  bit       ram_wr  [8192];
  int       we_seen = 0;
  always @(posedge clk_pixel) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_wr[ram_addr]  <= 1'b1;
      we_seen           <= we_seen + 1;
    end
    ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : (ram_addr[7:0] ^ 8'h5A);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model: per-edge display schedule and expected strobes indexed by the edge at
  // which the DUT output is sampled.
  bit        dsched  [ALEN];
  bit [12:0] daddr   [ALEN];
  bit        exp_dv  [ALEN];
  bit [7:0]  exp_dd  [ALEN];
  bit        exp_ack [ALEN];
  bit        exp_isrd[ALEN];
  bit [7:0]  exp_rd  [ALEN];
  bit [7:0]  ref_mem [8192];
  bit        ref_wr  [8192];
  int        last_commit = -1;
  int        wr_count    = 0;

  bit        dir_we  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit [12:0] dir_addr[4] = '{13'h1234, 13'h1234, 13'h0010, 13'h0010};
  bit [7:0]  dir_wd  [4] = '{8'hA5, 8'h00, 8'h3C, 8'h00};

  function automatic int first_free(input int from);
    int e = from;
    while (e < ALEN - 1 && dsched[e]) e++;
    return e;
  endfunction

  function automatic bit [7:0] ref_read(input bit [12:0] a);
    return ref_wr[a] ? ref_mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  // Present a CPU request at edge a and predict the edge its ack is sampled at.
  task automatic start_cpu(input int a, input bit we, input bit [12:0] addr, input bit [7:0] wd,
                           output int ack_at);
    int iss;
`ifdef VRAM_ARB_WBUF_EN
    int ld;
`endif
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
`ifdef VRAM_ARB_WBUF_EN
    if (we) begin
      ld          = (last_commit < a) ? a : last_commit + 1;
      ack_at      = ld + 1;
      last_commit = first_free(ld + 1);
    end else begin
      iss    = first_free((last_commit < a) ? a + 1 : last_commit + 1);
      ack_at = iss + 3;
    end
`else
    iss    = first_free(a + 1);
    ack_at = iss + 3;
`endif
    exp_ack[ack_at] = 1'b1;
    if (we) begin
      ref_mem[addr] = wd;
      ref_wr[addr]  = 1'b1;
      wr_count++;
    end else begin
      exp_isrd[ack_at] = 1'b1;
      exp_rd[ack_at]   = ref_read(addr);
    end
  endtask

  initial begin
    int        rq;
    int        ack_at;
    int        nxt;
    int        di;
    int        lat;
    bit        got_ack;
    bit        rwe;
    bit [12:0] ra;
    bit [7:0]  rwd;

    for (int k = 0; k < 32; k++) begin
      dsched[2 + 8 * k] = 1'b1;
      daddr[2 + 8 * k]  = 13'(k);
    end
    nxt = NDISP_ONLY;
    while (nxt < NCYC - TAIL) begin
      dsched[nxt] = 1'b1;
      daddr[nxt]  = 13'h1800 + 13'($urandom_range(0, 'h7FF));
      nxt += ($urandom_range(0, 3) == 0) ? 2 : $urandom_range(2, 9);
    end

    @(posedge clk_pixel);
    #1;
    check_val("reset_ram_outputs", {ram_addr, ram_we, ram_wdata}, 0);
    check_val("reset_client_outputs", {disp_data, disp_valid, cpu_rdata, cpu_ack}, 0);
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel);
    reset_n = 1'b1;

    rq     = 0;
    di     = 0;
    ack_at = -1;
    for (int e = 0; e < NCYC; e++) begin
      disp_req  = dsched[e];
      disp_addr = daddr[e];
      if (dsched[e]) begin
        exp_dv[e + 3] = 1'b1;
        exp_dd[e + 3] = daddr[e][7:0] ^ 8'h5A;
      end
      if (rq == 2) begin
        rq = 0;  // ack edge: request is still held here
      end else if (rq == 0) begin
        cpu_req = 1'b0;
        if (e >= NDISP_ONLY && e < NCYC - TAIL) begin
          if (di < 4) begin
            start_cpu(e, dir_we[di], dir_addr[di], dir_wd[di], ack_at);
            di++;
            rq = 1;
          end else if ($urandom_range(0, 2) == 0) begin
            rwe = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 15))
                                              : 13'($urandom_range(0, 'h17FF));
            rwd = 8'($urandom);
            start_cpu(e, rwe, ra, rwd, ack_at);
            rq = 1;
          end
        end
      end
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      check_val("disp_valid", disp_valid, exp_dv[e + 1]);
      if (exp_dv[e + 1]) check_val("disp_data", disp_data, exp_dd[e + 1]);
      check_val("cpu_ack", cpu_ack, exp_ack[e + 1]);
      if (exp_ack[e + 1] && exp_isrd[e + 1]) check_val("cpu_rdata", cpu_rdata, exp_rd[e + 1]);
      if (e < NDISP_ONLY) check_val("ram_we_display_only", ram_we, 0);
      if (rq == 1 && ack_at == e + 1) rq = 2;
    end
    check_val("ram_write_count", we_seen, wr_count);

    // Reset while a CPU read waits for its data and a display fetch is in flight.
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 13'h0100;
    disp_req  = 1'b0;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    disp_req  = 1'b1;
    disp_addr = 13'h1A5A;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    disp_req = 1'b0;
    cpu_req  = 1'b0;
    check_val("ram_addr_before_reset", ram_addr, 13'h1A5A);
    reset_n = 1'b0;
    #1;
    check_val("midrst_ram_outputs", {ram_addr, ram_we, ram_wdata}, 0);
    check_val("midrst_client_outputs", {disp_data, disp_valid, cpu_rdata, cpu_ack}, 0);
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      check_val("post_reset_no_valid", disp_valid, 0);
      check_val("post_reset_no_ack", cpu_ack, 0);
    end

    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0100;
    lat      = 0;
    got_ack  = 1'b0;
    while (!got_ack && lat < 20) begin
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      lat++;
      got_ack = cpu_ack;
    end
    check_val("fresh_read_latency", lat, 4);
    check_val("fresh_read_data", cpu_rdata, ref_read(13'h0100));
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    cpu_req = 1'b0;
    repeat (4) @(posedge clk_pixel);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter sharing the 8 KB display memory between the HDMI display fetcher and the CPU bus. Display fetches have absolute priority and fixed latency, so scanout never slips; CPU reads and writes fill the remaining slots through a req/ack handshake. The block sits between the CPU address decoder, the display controller's fetch port and the single RAM port, all in the pixel clock domain.

## Interface
- ADDR_W, 13, RAM address width (8 KB)
- DATA_W, 8, RAM data width
- clk_pixel  in  1  pixel clock (25 MHz); sole clock
- reset_n  in  1  asynchronous, active-low reset
- disp_req  in  1  one-cycle fetch strobe from display controller
- disp_addr  in  ADDR_W  fetch address, valid with disp_req
- disp_data  out  DATA_W  fetched byte
- disp_valid  out  1  one-cycle strobe, disp_data valid
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads
- cpu_ack  out  1  one-cycle completion strobe
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr (synchronous read)

## Operation
- Each cycle the slot selector picks one access: disp_req if high; else pending CPU access; else idle (ram_we=0, ram_addr holds).
- Display never stalls. Callers guarantee disp_req no more than once per 2 cycles (controller issues once per 8).
- Tag pipeline: stage-1 tag {NONE, DISP, CPU_RD, CPU_WR} registered with ram_addr; stage-2 tag aligned with ram_rdata. Stage-2 DISP loads disp_data and pulses disp_valid; CPU_RD loads cpu_rdata and pulses cpu_ack; CPU_WR pulses cpu_ack.
- CPU FSM: IDLE -> BUSY when cpu_req=1 and cpu_ack=0 (accepted); in BUSY, issue when slot free (no disp_req that cycle) -> WAIT; WAIT -> IDLE the cycle cpu_ack is driven. cpu_req seen together with cpu_ack is not a new request; requester drops cpu_req the cycle after cpu_ack.
- disp_req and CPU issue in the same cycle: display wins, CPU stays BUSY and retries next cycle.
- Reset (any time): FSM IDLE, tags NONE, in-flight accesses discarded, no ack/valid afterwards for them. Outputs at reset: disp_data=0, disp_valid=0, cpu_rdata=0, cpu_ack=0, ram_addr=0, ram_we=0, ram_wdata=0.

## Timing
- Display: disp_req at edge N -> ram_addr at N+1 -> ram_rdata at N+2 -> disp_valid/disp_data at N+3. Fixed 3 cycles, independent of CPU traffic.
- CPU, uncontended: cpu_req sampled N (accept) -> issue N+1 -> ram_addr N+2 -> cpu_ack N+4. Minimum 4 cycles.
- Each displacing disp_req adds exactly 1 cycle to CPU latency.
- Write reaches RAM at ram_addr cycle; a CPU read issued after a write's issue sees new data.

## Configuration
- VRAM_ARB_WBUF_EN defined: one-entry posted write buffer. Accepted write acks at N+1 (stage-2 path bypassed), data parked in buffer, committed in first free slot. A CPU read or second write while buffer is full stays BUSY until the buffer drains (read-after-write coherent). Reset empties buffer, discarding unwritten data.
- Undefined: no buffer; writes ack through the tag pipeline as above.

## Test plan
- Display only: disp_req every 8 cycles, addr 0x0000..0x001F, RAM preloaded addr[7:0]^0x5A -> disp_valid exactly 3 cycles after each strobe, correct bytes, ram_we=0 throughout.
- CPU write/read uncontended: write 0xA5 to 0x1234, then read 0x1234 -> each cpu_ack 4 cycles after accept (write ack 1 cycle with VRAM_ARB_WBUF_EN), cpu_rdata=0xA5.
- Collision: cpu_req read 0x0100 accepted, disp_req 0x0200 on CPU issue cycle -> disp_valid at +3 unchanged, cpu_ack delayed by exactly 1 cycle, both data correct.
- Held request: cpu_req kept high one cycle past cpu_ack -> no second RAM access, one ack only.
- Reset mid-operation: reset_n low during CPU read WAIT and display fetch -> all outputs 0 immediately, no cpu_ack/disp_valid after release; next request behaves as fresh.
- Write buffer (WBUF_EN): write 0x3C to 0x0010, immediately read 0x0010 under disp_req every 2 cycles -> write committed before read, cpu_rdata=0x3C, display latency still 3.
